pe_requant_collector: RTL and testbench

Downstream stage of the convolution PE. Captures each valid 48-bit partial-sum result qualified by the PE's `o_en`, then adds a per-filter bias and rescales by an arithmetic right shift with rounding. It saturates the result to a narrow signed activation, buffers it in a small first-word-fall-through FIFO, and hands it to the next layer over a valid/ready handshake, with row/column tracking and an end-of-frame marker.

---
 rtl/pe_requant_collector.sv | 141 ++++++++++++++
 tb/tb_pe_requant_collector.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_requant_collector.sv
// rtl/pe_requant_collector.sv - bias add, rounding requantisation, saturation and FWFT output FIFO for PE results
// Optional feature macro: RELU_EN (clamps negative activations to zero).
module pe_requant_collector #(
  parameter int FM_SIZE     = 5,
  parameter int KERNEL_SIZE = 4,
  parameter int STRIDE      = 1,
  parameter int OUT_WIDTH   = 8,
  parameter int BIAS_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  localparam int OUTPUT_DSP_WIDTH = 48,
  localparam int OUT_SIZE = (FM_SIZE - KERNEL_SIZE) / STRIDE + 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_en,
  input  logic signed [OUTPUT_DSP_WIDTH-1:0] i_P,
  input  logic signed [BIAS_WIDTH-1:0]       i_bias,
  input  logic [5:0]                         i_shift,
  output logic signed [OUT_WIDTH-1:0]        o_data,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_last,
  output logic                               o_overflow,
  output logic                               o_frame_done
);

  localparam int SUM_W = OUTPUT_DSP_WIDTH + 1;
  localparam int RND_W = OUTPUT_DSP_WIDTH + 2;
  localparam int CNT_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] POS_MAX = CNT_W'(OUT_SIZE - 1);
  localparam logic signed [RND_W-1:0] SAT_MAX = (RND_W'(1) <<< (OUT_WIDTH - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] SAT_MIN = -SAT_MAX - RND_W'(1);

  logic signed [SUM_W-1:0]     s1_sum;
  logic                        s1_valid;
  logic signed [RND_W-1:0]     rnd_bias;
  logic signed [RND_W-1:0]     rnd_sum;
  logic signed [RND_W-1:0]     shifted;
  logic signed [OUT_WIDTH-1:0] act;
  logic [CNT_W-1:0]            col;
  logic [CNT_W-1:0]            row;
  logic                        at_last;
  logic [OUT_WIDTH:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 count;
  logic                        full;
  logic                        push;
  logic                        pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= i_en;
    end
  end

  // One extra bit keeps the largest result plus bias from wrapping.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      s1_sum <= SUM_W'(i_P) + SUM_W'(i_bias);
    end
  end

  always_comb begin
    rnd_bias = '0;
    if (i_shift != 6'd0) begin
      rnd_bias = RND_W'(1) <<< (i_shift - 6'd1);
    end
    rnd_sum = RND_W'(s1_sum) + rnd_bias;
    shifted = rnd_sum >>> i_shift;
    if (shifted > SAT_MAX) begin
      act = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      act = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      act = shifted[OUT_WIDTH-1:0];
    end
`ifdef RELU_EN
    if (shifted < 0) begin
      act = '0;
    end
`else
`endif
  end

  assign at_last = (col == POS_MAX) && (row == POS_MAX);

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign full    = count == (AW + 1)'(FIFO_DEPTH);
  assign o_valid = count != '0;
  assign pop     = o_valid & i_ready;
  assign push    = s1_valid & (~full | pop);
  assign {o_last, o_data} = o_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {at_last, act};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      col          <= '0;
      row          <= '0;
      o_overflow   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= s1_valid & at_last;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (s1_valid & ~push) begin
        o_overflow <= 1'b1;
      end
      // Dropped results still advance the position so frames stay aligned.
      if (s1_valid) begin
        if (col == POS_MAX) begin
          col <= '0;
          row <= (row == POS_MAX) ? '0 : row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_requant_collector.sv
// tb/tb_pe_requant_collector.sv - randomized self-checking bench for pe_requant_collector
module tb_pe_requant_collector;
  localparam int OW    = 8;
  localparam int DEPTH = 16;
  localparam int OSZ   = 2;
  localparam int FRAME = OSZ * OSZ;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_en = 1'b0;
  logic               i_ready = 1'b0;
  logic signed [47:0] i_P = '0;
  logic signed [31:0] i_bias = '0;
  logic [5:0]         i_shift = '0;
  logic signed [7:0]  o_data;
  logic               o_valid;
  logic               o_last;
  logic               o_overflow;
  logic               o_frame_done;

  int checks = 0;
  int failures = 0;
  int pos = 0;
  int fd_cnt = 0;
  logic [OW:0] exp_q[$];
  logic [OW:0] rx_q[$];

  always #5 clk = ~clk;

  pe_requant_collector #(
    .FM_SIZE(5), .KERNEL_SIZE(4), .STRIDE(1), .OUT_WIDTH(OW), .BIAS_WIDTH(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_P(i_P), .i_bias(i_bias), .i_shift(i_shift),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_overflow(o_overflow), .o_frame_done(o_frame_done)
  );

  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) rx_q.push_back({o_last, o_data});
    if (o_frame_done) fd_cnt <= fd_cnt + 1;
  end

  function automatic logic [OW-1:0] ref_val(input longint p, input longint b, input int sh);
    longint s, r;
    longint maxv;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    s = p + b;
    if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
    r = s >>> sh;
    if (r > maxv) r = maxv;
    else if (r < -maxv - 1) r = -maxv - 1;
`ifdef RELU_EN
    if (r < 0) r = 0;
`else
`endif
    return r[OW-1:0];
  endfunction

  task automatic model_push(input longint p, input bit drop);
    bit last;
    last = (pos == FRAME - 1);
    pos = last ? 0 : pos + 1;
    if (!drop) exp_q.push_back({last, ref_val(p, longint'(i_bias), int'(i_shift))});
  endtask

  task automatic drive(input bit en, input longint p, input bit drop, input bit rdy);
    @(posedge clk);
    #2;
    i_en = en;
    i_P = p[47:0];
    i_ready = rdy;
    if (en) model_push(p, drop);
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  function automatic longint rand_p();
    longint p;
    p = {$urandom(), $urandom()};
    return p >>> (16 + $urandom_range(0, 40));
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    checks++; if (o_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", o_last); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", o_overflow); end
    checks++; if (o_frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", o_frame_done); end
    checks++; if (o_data !== 8'sd0) begin failures++; $display("FAIL rst_data got=%0d exp=0", o_data); end
    @(posedge clk);
    #2 i_rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [OW:0] e, got;
    int n;
    i_bias = 0; i_shift = 0;
    drive(0, 0, 0, 1);
    drive(1, 5, 0, 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b exp=0", o_valid); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", o_valid); end
    checks++; if (o_data !== 8'sd5) begin failures++; $display("FAIL lat_data got=%0d exp=5", o_data); end
    drive(1, 300, 0, 1);
    drive(1, -300, 0, 1);
    drive(0, 0, 0, 1);
    wait_rx(exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin failures++; $display("FAIL sat_out[%0d] got=none exp=%h", k, e); end
      else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL sat_out[%0d] got=%h exp=%h", k, got, e); end end
    end
  endtask

  task automatic test_rounding();
    logic [OW:0] e, got;
    int n;
    i_bias = 0; i_shift = 4;
    drive(0, 0, 0, 1);
    drive(1, 24, 0, 1);
    drive(1, 23, 0, 1);
    drive(1, -24, 0, 1);
    for (int k = 0; k < 6; k++) drive(1, longint'($signed(12'($urandom()))), 0, 1);
    drive(0, 0, 0, 1);
    wait_rx(exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin failures++; $display("FAIL round_out[%0d] got=none exp=%h", k, e); end
      else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL round_out[%0d] got=%h exp=%h", k, got, e); end end
    end
  endtask

  task automatic test_bias();
    logic [OW:0] e, got;
    int n;
    i_bias = -10; i_shift = 0;
    drive(0, 0, 0, 1);
    drive(1, 7, 0, 1);
    drive(0, 0, 0, 1);
    i_bias = 100;
    drive(1, 64'sh7FFF_FFFF_FFFF, 0, 1);
    drive(0, 0, 0, 1);
    i_bias = -100;
    drive(1, -64'sh8000_0000_0000, 0, 1);
    drive(0, 0, 0, 1);
    wait_rx(exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin failures++; $display("FAIL bias_out[%0d] got=none exp=%h", k, e); end
      else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL bias_out[%0d] got=%h exp=%h", k, got, e); end end
    end
  endtask

  task automatic test_random();
    logic [OW:0] e, got;
    int n;
    int bb;
    for (int rnd = 0; rnd < 4; rnd++) begin
      bb = $urandom();
      i_bias = bb >>> $urandom_range(0, 31);
      i_shift = 6'($urandom_range(0, 47));
      drive(0, 0, 0, 1);
      for (int c = 0; c < 30; c++) drive($urandom_range(0, 1) == 1, rand_p(), 0, $urandom_range(0, 3) != 0);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      wait_rx(exp_q.size());
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (rx_q.size() == 0) begin failures++; $display("FAIL rand_out[%0d.%0d] got=none exp=%h", rnd, k, e); end
        else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL rand_out[%0d.%0d] got=%h exp=%h", rnd, k, got, e); end end
      end
    end
  endtask

  task automatic test_frame();
    logic [OW:0] e, got;
    int n, fd0;
    @(posedge clk); #2 i_rst = 1'b1; i_en = 1'b0;
    @(posedge clk); #2 i_rst = 1'b0;
    exp_q.delete(); rx_q.delete(); pos = 0;
    i_bias = 0; i_shift = 2;
    @(negedge clk);
    fd0 = fd_cnt;
    for (int k = 0; k < FRAME; k++) drive(1, rand_p() >>> 20, 0, 1);
    repeat (4) drive(0, 0, 0, 1);
    wait_rx(exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin failures++; $display("FAIL frame_out[%0d] got=none exp=%h", k, e); end
      else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL frame_out[%0d] got=%h exp=%h", k, got, e); end end
    end
    checks++; if (fd_cnt - fd0 !== 1) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=1", fd_cnt - fd0); end
  endtask

  task automatic test_backpressure();
    logic [OW:0] e, got;
    int n;
    i_bias = 3; i_shift = 1;
    drive(0, 0, 0, 0);
    for (int k = 0; k < DEPTH + 1; k++) drive(1, rand_p() >>> 24, k == DEPTH, 0);
    repeat (3) drive(0, 0, 0, 0);
    @(negedge clk);
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", o_overflow); end
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", o_valid); end
    checks++; if (o_data !== exp_q[0][OW-1:0]) begin failures++; $display("FAIL bp_head got=%0d exp=%0d", o_data, $signed(exp_q[0][OW-1:0])); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL bp_no_transfer got=%0d exp=0", rx_q.size()); end
    @(negedge clk);
    checks++; if (o_data !== exp_q[0][OW-1:0]) begin failures++; $display("FAIL bp_hold got=%0d exp=%0d", o_data, $signed(exp_q[0][OW-1:0])); end
    drive(1, rand_p() >>> 24, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    wait_rx(exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin failures++; $display("FAIL bp_out[%0d] got=none exp=%h", k, e); end
      else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL bp_out[%0d] got=%h exp=%h", k, got, e); end end
    end
    repeat (3) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL bp_extra got=%0d exp=0", rx_q.size()); end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%b exp=1", o_overflow); end
  endtask

  task automatic test_reset_midop();
    logic [OW:0] e, got;
    int n, fd0;
    i_bias = 0; i_shift = 0;
    drive(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(1, rand_p() >>> 30, 0, 0);
    @(posedge clk); #2 i_en = 1'b0; i_rst = 1'b1;
    @(posedge clk); #2 i_rst = 1'b0;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", o_overflow); end
    exp_q.delete(); rx_q.delete(); pos = 0;
    fd0 = fd_cnt;
    for (int k = 0; k < FRAME + 2; k++) drive(1, rand_p() >>> 30, 0, 1);
    repeat (4) drive(0, 0, 0, 1);
    wait_rx(exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin failures++; $display("FAIL midrst_out[%0d] got=none exp=%h", k, e); end
      else begin got = rx_q.pop_front(); if (got !== e) begin failures++; $display("FAIL midrst_out[%0d] got=%h exp=%h", k, got, e); end end
    end
    checks++; if (fd_cnt - fd0 !== 1) begin failures++; $display("FAIL midrst_frame_done got=%0d exp=1", fd_cnt - fd0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_bias();
    test_random();
    test_frame();
    test_backpressure();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
